// File: rtl/vectored_int_ctrl_pkg.sv
// Shared types and defaults for the vectored interrupt controller.
package vectored_int_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } int_state_t;

  localparam logic [31:0] VEC_BASE_DEF  = 32'h0000_0080;
  localparam int          VEC_SHIFT_DEF = 3;
  localparam int          N_IRQ_MAX     = 8;

  // Width of an index into n request lines (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vectored_int_ctrl_prio_enc.sv
// Lowest-index-first priority encoder: line 0 has the highest priority.
module vectored_int_ctrl_prio_enc
  import vectored_int_ctrl_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vectored_int_ctrl.sv
// Prioritized vectored interrupt controller feeding the core's interrupt
// encoder. Owns pending/enable bits, EPC and the in-service status.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | no request outstanding; picks the best eligible line
//   ST_REQ     | int_req high, idx and vector frozen until ack or disable
//   ST_SERVICE | handler running, status_bit high, waits for eret
module vectored_int_ctrl
  import vectored_int_ctrl_pkg::*;
#(
  parameter int          N_IRQ     = 4,
  parameter logic [31:0] VEC_BASE  = VEC_BASE_DEF,
  parameter int          VEC_SHIFT = VEC_SHIFT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic             ien_we,
  input  logic [N_IRQ-1:0] ien_wd,
  output logic             int_req,
  output logic [31:0]      vector,
  input  logic             int_ack,
  input  logic [31:0]      pc_ret,
  input  logic             eret,
  output logic [31:0]      epc,
  output logic             status_bit,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] ien
);

  localparam int IW = idx_width(N_IRQ);

  if (N_IRQ < 1 || N_IRQ > N_IRQ_MAX) begin : g_bad_n_irq
    $error("vectored_int_ctrl: N_IRQ out of range");
  end

  int_state_t       state, state_nxt;
  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] irq_edge;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] clr_mask;
  logic [IW-1:0]    sel_idx;
  logic             sel_valid;
  logic [31:0]      sel_vec;
  logic [IW-1:0]    idx_q;
  logic             latch_sel;
  logic             take_ack;

  assign irq_edge = irq & ~irq_q;
  assign eligible = pending & ien;

  vectored_int_ctrl_prio_enc #(
    .N  (N_IRQ),
    .IW (IW)
  ) u_prio_enc (
    .req   (eligible),
    .idx   (sel_idx),
    .valid (sel_valid)
  );

  assign sel_vec  = VEC_BASE + (32'(sel_idx) << VEC_SHIFT);
  assign clr_mask = take_ack ? (N_IRQ'(1) << idx_q) : '0;

  assign int_req    = (state == ST_REQ);
  assign status_bit = (state == ST_SERVICE);

  // irq_q keeps tracking irq through reset so a line already high when
  // reset releases is not mistaken for a fresh event.
  always_ff @(posedge clk) begin
    irq_q <= irq;
  end

  // State register plus the pending/enable/vector/EPC storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      pending <= '0;
      ien     <= '0;
      idx_q   <= '0;
      vector  <= '0;
      epc     <= '0;
    end else begin
      state   <= state_nxt;
      // A new edge on the line being acknowledged wins over the clear.
      pending <= (pending & ~clr_mask) | irq_edge;
      if (ien_we) begin
        ien <= ien_wd;
      end
      if (latch_sel) begin
        idx_q  <= sel_idx;
        vector <= sel_vec;
      end
      if (take_ack) begin
        epc <= pc_ret;
      end
    end
  end

  // Next-state logic; ack takes precedence over a disable of the same line.
  always_comb begin
    state_nxt = state;
    latch_sel = 1'b0;
    take_ack  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sel_valid) begin
          state_nxt = ST_REQ;
          latch_sel = 1'b1;
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          state_nxt = ST_SERVICE;
          take_ack  = 1'b1;
        end else if (!ien[idx_q]) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (eret) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_vectored_int_ctrl.sv
// Self-checking bench for vectored_int_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_vectored_int_ctrl;

  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'h0000_0080;
  localparam int          SH   = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  irq;
  logic          ien_we;
  logic [N-1:0]  ien_wd;
  logic          int_req;
  logic [31:0]   vector;
  logic          int_ack;
  logic [31:0]   pc_ret;
  logic          eret;
  logic [31:0]   epc;
  logic          status_bit;
  logic [N-1:0]  pending;
  logic [N-1:0]  ien;

  int compared = 0;
  int mismatched = 0;
  bit chk_en = 1'b0;

  vectored_int_ctrl #(
    .N_IRQ     (N),
    .VEC_BASE  (BASE),
    .VEC_SHIFT (SH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .ien_we     (ien_we),
    .ien_wd     (ien_wd),
    .int_req    (int_req),
    .vector     (vector),
    .int_ack    (int_ack),
    .pc_ret     (pc_ret),
    .eret       (eret),
    .epc        (epc),
    .status_bit (status_bit),
    .pending    (pending),
    .ien        (ien)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0 = idle, 1 = requesting, 2 = in service.
  int          m_mode = 0;
  int          m_idx = 0;
  logic [31:0] m_vec = '0;
  logic [31:0] m_epc = '0;
  bit          m_pend [N];
  bit          m_en   [N];
  bit          m_prev [N];

  always @(posedge clk) begin
    bit new_pend [N];
    int best;
    if (reset) begin
      m_mode = 0;
      m_idx  = 0;
      m_vec  = '0;
      m_epc  = '0;
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0;
        m_en[i]   = 0;
        m_prev[i] = irq[i];
      end
    end else begin
      best = -1;
      for (int i = N - 1; i >= 0; i--)
        if (m_pend[i] && m_en[i]) best = i;
      for (int i = 0; i < N; i++) new_pend[i] = m_pend[i];
      if (m_mode == 0) begin
        if (best >= 0) begin
          m_mode = 1;
          m_idx  = best;
          m_vec  = BASE + best * (1 << SH);
        end
      end else if (m_mode == 1) begin
        if (int_ack) begin
          new_pend[m_idx] = 0;
          m_epc  = pc_ret;
          m_mode = 2;
        end else if (!m_en[m_idx]) begin
          m_mode = 0;
        end
      end else begin
        if (eret) m_mode = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (irq[i] && !m_prev[i]) new_pend[i] = 1;
        m_prev[i] = irq[i];
        m_pend[i] = new_pend[i];
        if (ien_we) m_en[i] = ien_wd[i];
      end
    end
  end

  function automatic logic [N-1:0] pack(input bit a [N]);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = a[i];
    return r;
  endfunction

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      compared++;
      if (int_req !== (m_mode == 1) || status_bit !== (m_mode == 2) ||
          vector !== m_vec || epc !== m_epc ||
          pending !== pack(m_pend) || ien !== pack(m_en)) begin
        mismatched++;
        $display("FAIL model_cmp t=%0t got req=%b st=%b vec=%h epc=%h pend=%b ien=%b want req=%b st=%b vec=%h epc=%h pend=%b ien=%b",
                 $time, int_req, status_bit, vector, epc, pending, ien,
                 (m_mode == 1), (m_mode == 2), m_vec, m_epc, pack(m_pend), pack(m_en));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic wr_ien(input logic [N-1:0] v);
    ien_we = 1'b1;
    ien_wd = v;
    tick();
    ien_we = 1'b0;
  endtask

  task automatic do_ack(input logic [31:0] pc);
    int_ack = 1'b1;
    pc_ret  = pc;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irq = '0; ien_we = 1'b0; ien_wd = '0;
    int_ack = 1'b0; pc_ret = '0; eret = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_req", {31'd0, int_req}, 32'd0);
    chk("rst_pend", {28'd0, pending}, 32'd0);

    // Single line 2 request, ack, eret.
    wr_ien(4'b1111);
    irq = 4'b0100;
    tick();
    chk("t1_pend", {28'd0, pending}, 32'h4);
    chk("t1_req_early", {31'd0, int_req}, 32'd0);
    tick();
    chk("t1_req", {31'd0, int_req}, 32'd1);
    chk("t1_vec", vector, 32'h90);
    do_ack(32'h44);
    chk("t1_epc", epc, 32'h44);
    chk("t1_status", {31'd0, status_bit}, 32'd1);
    chk("t1_pend_clr", {28'd0, pending}, 32'd0);
    do_eret();
    irq = '0;
    tick();

    // Lines 3 and 1 together: line 1 first, then line 3.
    irq = 4'b1010;
    tick(); tick();
    chk("t2_vec1", vector, 32'h88);
    do_ack(32'h100);
    do_eret();
    tick();
    chk("t2_req3", {31'd0, int_req}, 32'd1);
    chk("t2_vec3", vector, 32'h98);
    do_ack(32'h104);
    do_eret();
    irq = '0;

    // Disabled event is retained and fires once enabled.
    wr_ien(4'b0000);
    irq = 4'b0001;
    tick();
    chk("t3_pend0", {31'd0, pending[0]}, 32'd1);
    tick();
    chk("t3_noreq", {31'd0, int_req}, 32'd0);
    wr_ien(4'b0001);
    tick();
    chk("t3_req", {31'd0, int_req}, 32'd1);
    chk("t3_vec", vector, 32'h80);
    do_ack(32'h200);
    do_eret();
    irq = '0;

    // Vector stays frozen while a higher-priority line arrives.
    wr_ien(4'b1111);
    irq = 4'b0100;
    tick(); tick();
    irq = 4'b0101;
    tick(); tick();
    chk("t4_frozen", vector, 32'h90);
    do_ack(32'h300);
    do_eret();
    tick();
    chk("t4_vec0", vector, 32'h80);
    do_ack(32'h304);
    do_eret();
    irq = '0;
    tick();

    // Stray ack in IDLE and stray eret in REQ are ignored.
    int_ack = 1'b1; pc_ret = 32'hDEAD_BEEF;
    tick();
    int_ack = 1'b0;
    chk("t5_epc_hold", epc, 32'h304);
    chk("t5_idle_st", {31'd0, status_bit}, 32'd0);
    irq = 4'b0010;
    tick(); tick();
    do_eret();
    chk("t5_req_hold", {31'd0, int_req}, 32'd1);
    chk("t5_vec_hold", vector, 32'h88);
    do_ack(32'h400);

    // Reset in service with lines held high afterwards.
    irq = '0;
    tick();
    irq = 4'b1010;
    tick();
    chk("t6_pend", {28'd0, pending}, 32'hA);
    chk("t6_status", {31'd0, status_bit}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_all", {status_bit, int_req, pending, ien, 24'd0} | epc | vector, 32'd0);
    tick(); tick();
    chk("t6_no_event", {28'd0, pending}, 32'd0);

    // Randomized traffic, checked every cycle by the model compare.
    for (int c = 0; c < 3000; c++) begin
      irq     = irq ^ N'($urandom & $urandom & $urandom);
      ien_we  = ($urandom_range(0, 7) == 0);
      ien_wd  = N'($urandom);
      int_ack = int_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      eret    = ($urandom_range(0, 4) == 0);
      pc_ret  = $urandom;
      reset   = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0; ien_we = 1'b0; int_ack = 1'b0; eret = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
